weight_rom_streamer: RTL

- Parametrised successor to the fixed 6-entry weight ROM used by the mapping layer.
- Holds DEPTH words of WIDTH bits, initialised from a packed parameter, and can be reloaded at run time through a write port.
- On `start` it streams the whole table, address 0 to DEPTH-1, for a programmable number of passes.
- Output is a registered valid/ready stream with per-pass and final `last` flags, feeding the PE weight inputs.

---
 rtl/weight_rom_streamer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/weight_rom_streamer.sv
// Reloadable DEPTH x WIDTH weight table streamed out as a registered
// valid/ready sequence, repeated for a programmable number of passes.
module weight_rom_streamer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 6,
    parameter logic [DEPTH*WIDTH-1:0] INIT_DATA = {
        24'hE87F7F, 24'h7FD6B5, 24'h10D3E8,
        24'hE87F7F, 24'h7FD6B5, 24'h10D3E8
    },
    parameter int PASS_W = 8,
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] passes,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic [AW-1:0]     m_addr,
    output logic              m_pass_last,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PASS_W-1:0] rem;
    logic [PASS_W-1:0] ld_rem;
    logic [AW-1:0]     ld_addr;
    logic              load;
    logic              fin;
    logic              hs;

    assign hs = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= INIT_DATA[i*WIDTH +: WIDTH];
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        fin      = 1'b0;
        ld_addr  = '0;
        ld_rem   = rem;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = STREAM;
                    load     = 1'b1;
                    ld_rem   = (passes == '0) ? PASS_W'(1) : passes;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (m_last) begin
                        state_nx = IDLE;
                        fin      = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (m_pass_last) begin
                            ld_addr = '0;
                            ld_rem  = rem - PASS_W'(1);
                        end else begin
                            ld_addr = m_addr + AW'(1);
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output register samples the table before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_addr      <= '0;
            m_pass_last <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rem         <= '0;
        end else begin
            done <= fin;
            if (load) begin
                m_valid     <= 1'b1;
                m_data      <= mem[ld_addr];
                m_addr      <= ld_addr;
                m_pass_last <= (ld_addr == LAST_A);
                m_last      <= (ld_addr == LAST_A) && (ld_rem == PASS_W'(1));
                rem         <= ld_rem;
                busy        <= 1'b1;
            end else if (fin) begin
                m_valid     <= 1'b0;
                m_pass_last <= 1'b0;
                m_last      <= 1'b0;
                busy        <= 1'b0;
            end
        end
    end

endmodule
